// File: rtl/mult_div_unit_if.sv
// Handshake and result bundle between the control unit and mult_div_unit.
// The control unit is the master; the arithmetic block is the slave.
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output start, op, A, B,
    input  busy, done, div_zero, HI, LO
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, div_zero, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring on magnitudes)
// responder writing HI/LO for mfhi/mflo.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    FINISH,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              op_q, op_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              qm_q, qm_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] ph_q, ph_d;
  logic [DATA_W-1:0] pl_q, pl_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W:0]   booth_sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] trial;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    qm_d    = qm_q;
    dz_d    = dz_q;
    a_d     = a_q;
    b_d     = b_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    mag_a = bus.A[DATA_W-1] ? -bus.A : bus.A;
    mag_b = bus.B[DATA_W-1] ? -bus.B : bus.B;

    // One guard bit keeps the -2^(W-1) * -2^(W-1) product exact.
    case ({pl_q[0], qm_q})
      2'b01:   booth_sum = {ph_q[DATA_W-1], ph_q}
                         + {a_q[DATA_W-1], a_q};
      2'b10:   booth_sum = {ph_q[DATA_W-1], ph_q}
                         - {a_q[DATA_W-1], a_q};
      default: booth_sum = {ph_q[DATA_W-1], ph_q};
    endcase

    rem_sh = {ph_q, pl_q[DATA_W-1]};
    trial  = {1'b0, rem_sh} - {2'b00, b_q};

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          sa_d  = bus.A[DATA_W-1];
          sb_d  = bus.B[DATA_W-1];
          a_d   = bus.A;
          b_d   = bus.op ? mag_b : bus.B;
          ph_d  = '0;
          pl_d  = bus.op ? mag_a : bus.B;
          qm_d  = 1'b0;
          cnt_d = '0;
          dz_d  = 1'b0;
          if (!bus.op) begin
            state_d = MULT_RUN;
          end else if (bus.B == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = DIV_RUN;
          end
        end
      end
      MULT_RUN: begin
        ph_d  = booth_sum[DATA_W:1];
        pl_d  = {booth_sum[0], pl_q[DATA_W-1:1]};
        qm_d  = pl_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W-1)) state_d = FINISH;
      end
      DIV_RUN: begin
        if (!trial[DATA_W+1]) begin
          ph_d = trial[DATA_W-1:0];
          pl_d = {pl_q[DATA_W-2:0], 1'b1};
        end else begin
          ph_d = rem_sh[DATA_W-1:0];
          pl_d = {pl_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W-1)) state_d = FINISH;
      end
      FINISH: begin
        if (op_q) begin
          lo_d = (sa_q ^ sb_q) ? -pl_q : pl_q;
          hi_d = sa_q ? -ph_q : ph_q;
        end else begin
          hi_d = ph_q;
          lo_d = pl_q;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      qm_q    <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      qm_q    <= qm_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = dz_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule
